// File: rtl/seg_pkg.sv
// Shared constants for the seven-segment scan driver.
//   HEX_SEG   : active-high segment pattern per hex nibble, bit0 = a .. bit6 = g
//   SEG_BLANK : active-high pattern with every segment off
//   idx_width : width of a digit index register, never below one bit
package seg_pkg;

  localparam logic [6:0] HEX_SEG [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  localparam logic [6:0] SEG_BLANK = 7'h00;

  function automatic int idx_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/hex_to_7seg.sv
// Combinational hex nibble to seven-segment decode (active-high).
//   digit_i : 4-bit hex value
//   seg_o   : segments {g,f,e,d,c,b,a}
module hex_to_7seg
  import seg_pkg::*;
(
  input  logic [3:0] digit_i,
  output logic [6:0] seg_o
);

  assign seg_o = HEX_SEG[digit_i];

endmodule

// File: rtl/seg_display_scan.sv
// Multiplexed seven-segment scanner with a double-buffered display value.
//   Clk, Reset : system clock, asynchronous active-high reset
//   Value/Load : new hex digits (digit 0 rightmost), captured when Load is high
//   DigitMask  : per-digit enable, 0 forces the digit blank (sampled live)
//   LzBlank    : suppress leading zeros (digit 0 is always shown)
//   DpMask     : per-digit decimal point (sampled live)
//   out7/dp    : segment and decimal-point drive for the selected digit
//   en_out     : one-hot digit enable
//   FrameDone  : one-cycle pulse after the last digit of each frame
// A new value is held in a pending buffer and only promoted to the displayed
// buffer at a frame boundary, so a frame never mixes old and new digits.
module seg_display_scan
  import seg_pkg::*;
#(
  parameter int NUM_DIGITS  = 8,
  parameter int REFRESH_DIV = 100000,
  parameter bit ACTIVE_LOW  = 1'b1
) (
  input  logic                    Clk,
  input  logic                    Reset,
  input  logic [4*NUM_DIGITS-1:0] Value,
  input  logic                    Load,
  input  logic [NUM_DIGITS-1:0]   DigitMask,
  input  logic                    LzBlank,
  input  logic [NUM_DIGITS-1:0]   DpMask,
  output logic [6:0]              out7,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   en_out,
  output logic                    FrameDone
);

  localparam int PW = $clog2(REFRESH_DIV);
  localparam int IW = idx_width(NUM_DIGITS);
  localparam int VW = 4 * NUM_DIGITS;

  localparam logic [PW-1:0]         PRESC_MAX = PW'(REFRESH_DIV - 1);
  localparam logic [IW-1:0]         IDX_MAX   = IW'(NUM_DIGITS - 1);
  // XOR masks that turn active-high patterns into the board polarity
  localparam logic [6:0]            SEG_POL   = {7{ACTIVE_LOW}};
  localparam logic [NUM_DIGITS-1:0] EN_POL    = {NUM_DIGITS{ACTIVE_LOW}};

  logic [PW-1:0]         presc_q, presc_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [VW-1:0]         active_q, active_d;
  logic [VW-1:0]         pending_q, pending_d;
  logic                  pend_q, pend_d;
  logic                  frame_done_q;
  logic                  upd_q;
  logic [6:0]            out7_q;
  logic                  dp_q;
  logic [NUM_DIGITS-1:0] en_q;

  logic                  tick;
  logic                  boundary;
  logic [3:0]            digit_sel;
  logic                  mask_sel;
  logic                  dp_sel;
  logic                  lz_sel;
  logic                  zero_run;
  logic [NUM_DIGITS-1:0] onehot;
  logic [6:0]            dec_seg;
  logic [6:0]            seg_hi;

  // Timing and buffer next-state
  always_comb begin
    tick     = (presc_q == PRESC_MAX);
    boundary = tick && (idx_q == IDX_MAX);

    presc_d = tick ? '0 : presc_q + 1'b1;

    idx_d = idx_q;
    if (tick) begin
      idx_d = (idx_q == IDX_MAX) ? '0 : idx_q + 1'b1;
    end

    active_d  = active_q;
    pending_d = pending_q;
    pend_d    = pend_q;
    if (Load && boundary) begin
      // Bypass the pending buffer so the value appears on the very next frame
      active_d  = Value;
      pending_d = Value;
      pend_d    = 1'b0;
    end else if (Load) begin
      pending_d = Value;
      pend_d    = 1'b1;
    end else if (boundary && pend_q) begin
      active_d = pending_q;
      pend_d   = 1'b0;
    end
  end

  // Digit select and blanking for the current index. The scan runs from the
  // most significant digit down so zero_run says whether every digit from
  // the top down to i is zero.
  always_comb begin
    digit_sel = 4'h0;
    mask_sel  = 1'b0;
    dp_sel    = 1'b0;
    lz_sel    = 1'b0;
    onehot    = '0;
    zero_run  = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      zero_run = zero_run && (active_q[4*i +: 4] == 4'h0);
      if (idx_q == IW'(i)) begin
        digit_sel = active_q[4*i +: 4];
        mask_sel  = DigitMask[i];
        dp_sel    = DpMask[i];
        lz_sel    = zero_run && (i != 0);
        onehot[i] = 1'b1;
      end
    end
  end

  hex_to_7seg u_dec (
    .digit_i (digit_sel),
    .seg_o   (dec_seg)
  );

  assign seg_hi = (!mask_sel || (LzBlank && lz_sel)) ? SEG_BLANK : dec_seg;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      presc_q      <= '0;
      idx_q        <= '0;
      active_q     <= '0;
      pending_q    <= '0;
      pend_q       <= 1'b0;
      frame_done_q <= 1'b0;
      upd_q        <= 1'b0;
      out7_q       <= SEG_BLANK ^ SEG_POL;
      dp_q         <= ACTIVE_LOW;
      en_q         <= EN_POL;
    end else begin
      presc_q      <= presc_d;
      idx_q        <= idx_d;
      active_q     <= active_d;
      pending_q    <= pending_d;
      pend_q       <= pend_d;
      frame_done_q <= boundary;
      // Outputs follow one cycle after each index step; until the first
      // step they keep their reset (all-off) value.
      upd_q        <= tick;
      if (upd_q) begin
        out7_q <= seg_hi ^ SEG_POL;
        dp_q   <= dp_sel ^ ACTIVE_LOW;
        en_q   <= onehot ^ EN_POL;
      end
    end
  end

  assign out7      = out7_q;
  assign dp        = dp_q;
  assign en_out    = en_q;
  assign FrameDone = frame_done_q;

endmodule

// File: doc/seg_display_scan.md
Name: seg_display_scan

Overview:
Parametrised multiplexed seven-segment driver, the next generation of the fixed two-by-four-digit display. It scans NUM_DIGITS hex digits at a programmable refresh rate and double-buffers the displayed value, so a new value never tears mid-frame. It also supports per-digit blanking, leading-zero suppression and decimal points. It sits under Top and is fed from the instruction fetch/datapath debug buses.

Parameters:
NUM_DIGITS, 8, number of digits scanned (1..16)
REFRESH_DIV, 100000, Clk cycles each digit stays enabled (>=2)
ACTIVE_LOW, 1, 1 = segment and enable outputs are active-low (board default); 0 = active-high

Ports:
Clk  in  1  system clock
Reset  in  1  asynchronous, active-high reset
Value  in  4*NUM_DIGITS  hex digits to show; digit i = Value[4i+3:4i]; digit 0 is rightmost
Load  in  1  capture Value into the pending buffer this cycle
DigitMask  in  NUM_DIGITS  1 = digit i displayed, 0 = forced blank (sampled live)
LzBlank  in  1  1 = suppress leading zeros
DpMask  in  NUM_DIGITS  1 = decimal point lit on digit i (sampled live)
out7  out  7  segments {g,f,e,d,c,b,a}
dp  out  1  decimal point
en_out  out  NUM_DIGITS  one-hot digit enable
FrameDone  out  1  one-cycle pulse at each frame boundary

Behaviour:
- Reset (async, any time including mid-frame):
  - prescaler=0, idx=0, active=0, pending=0, pend=0, FrameDone=0.
  - out7, dp and en_out are all inactive: all ones if ACTIVE_LOW, else all zeros.
- Prescaler:
  - Counts 0..REFRESH_DIV-1 and wraps.
  - tick = (prescaler==REFRESH_DIV-1).
- Digit index:
  - idx advances on tick, wrapping NUM_DIGITS-1 -> 0.
  - boundary = tick && idx==NUM_DIGITS-1.
- Buffering:
  - Load alone: pending<=Value, pend<=1. If pend is already 1, last Load wins.
  - boundary with pend=1: active<=pending, pend<=0.
  - Load in the same cycle as boundary: active<=Value directly, pend<=0, pending<=Value.
  - Without Load, active holds indefinitely.
- FrameDone: registered, high exactly the cycle after boundary.
- Blanking: digit i is blank if DigitMask[i]==0, or if LzBlank==1 and digits NUM_DIGITS-1..i of active are all zero. Digit 0 is never lz-blanked.
- Output pipeline, registered, one cycle after an idx change:
  - en_out one-hot at the new idx.
  - out7 = hex decode of active digit idx, or all segments off if blanked.
  - dp = DpMask[idx]; dp is not blanked by LzBlank.
  - All outputs are inverted when ACTIVE_LOW.
- Between reset and the first idx change, outputs stay at their reset value.
- Hex table (active-high, bit0=a):
  - 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07
  - 8=7F 9=6F A=77 b=7C C=39 d=5E E=79 F=71
- Widths: prescaler $clog2(REFRESH_DIV); idx $clog2(NUM_DIGITS), minimum 1 bit.

Decomposition:
- Package seg_pkg: 16-entry hex-to-segment constant table, SEG_BLANK constant, digit-index width function.
- Sub-module hex_to_7seg: combinational 4-bit -> 7-bit decode, instantiated once on the muxed digit.
- The scan/buffer logic stays in seg_display_scan.

Test Plan:
Bench uses NUM_DIGITS=8, REFRESH_DIV=4, ACTIVE_LOW=1.
1. Reset released, no Load -> all en_out go low in turn; each active digit shows out7=~7'h3F (=7'h40); FrameDone pulses every 32 cycles.
2. Load Value=32'h1234_ABCD mid-frame -> digits keep showing 0 until the next FrameDone; the following frame shows D,C,B,A,4,3,2,1 on idx 0..7 (digit0 out7=~7'h5E).
3. Two Loads in one frame (32'h1111_1111, then 32'h2222_2222) -> next frame shows only 2s. Load coincident with boundary -> that value appears on the very next frame.
4. Value=32'h0000_0050, LzBlank=1 -> digits 7..2 show out7=7'h7F (blank); digit1=~6D, digit0=~3F. DigitMask=8'hFE -> digit0 is blank too; dp follows DpMask=8'h04 on digit2 only.
5. Assert Reset while idx=5 with pend=1 -> outputs go to 7'h7F/8'hFF/dp=1 immediately. After release, active=0 and the pending value is discarded.
6. Parameter sweep NUM_DIGITS=1, REFRESH_DIV=2 -> en_out stays 1'b0 (always on); FrameDone pulses every 2 cycles; Load is displayed within 2 cycles.
